alu_control_fsm: RTL
====================

# alu_control_fsm

Multi-cycle control unit for the 16-bit CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the ALU's 3-bit operation select plus all datapath enables and multiplexer selects. It stalls on memory, resolves branches from the ALU zero flag, and traps on illegal opcodes. It sits between the instruction register and the datapath (ALU, register file, PC, memory port).

## Interface
Parameters:
- RESET_STATE, 4'd0: encoding of FETCH, which is entered on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  instruction bits [15:12] from the instruction register.
- alu_zero  in  1  high when the ALU result is 0.
- mem_ready  in  1  memory access completes this cycle.
- ALUOp  out  3  ALU operation select: 000 add, 010 sub, 100 and, 101 xor, 110 or.
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B source: 00 = register B, 01 = constant 1, 10 = sign-extended imm.
- pc_write, pc_write_cond, pc_source[1:0]  out  PC update controls. pc_source: 00 = ALU, 01 = ALUOut register, 10 = jump target.
- ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst  out  1 each  datapath enables and selects.
- illegal  out  1  high while in TRAP.
- state  out  4  current state, for debug.
- retired  out  16  count of completed instructions; wraps.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 J. Opcodes 10–15 are illegal.
- States: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, TRAP 11.
- FETCH: mem_read=1, ALUOp=000, src_a=0, src_b=01.
  - While mem_ready=0, remain in FETCH with no writes.
  - On mem_ready=1, assert ir_write and pc_write (pc_source 00), then go to DECODE.
- DECODE: ALUOp=000, src_a=0, src_b=10 (branch target precompute). Next state by opcode:
  - 0–4 → EXEC_R
  - 5 → EXEC_I
  - 6, 7 → ADDR
  - 8 → BRANCH
  - 9 → JUMP
  - else → TRAP
- EXEC_R: src_a=1, src_b=00, ALUOp from opcode (ADD 000, SUB 010, AND 100, XOR 101, OR 110). Next: WB_ALU.
- EXEC_I: src_a=1, src_b=10, ALUOp=000. Next: WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0. reg_dst=1 for R-type, 0 for ADDI. Retires; next FETCH.
- ADDR: src_a=1, src_b=10, ALUOp=000. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1; hold until mem_ready=1, then go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Retires; next FETCH.
- MEM_WR: mem_write=1; hold until mem_ready=1. Retires on that cycle; next FETCH.
- BRANCH: src_a=1, src_b=00, ALUOp=010, pc_write_cond=1, pc_source=01. The PC loads when alu_zero=1. Retires; next FETCH.
- JUMP: pc_write=1, pc_source=10. Retires; next FETCH.
- TRAP: illegal=1, all enables 0. TRAP is sticky; only reset exits it.
- Outputs not listed for a state are 0.
- retired increments by 1 on every retiring cycle. It wraps FFFF→0000.

## Timing
- Moore outputs, decoded combinationally from the registered state. The one exception is that FETCH ir_write/pc_write are gated by mem_ready.
- Zero-wait cycle counts:
  - R-type and ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes and selects are held stable throughout the stall.
- Reset:
  - While reset=1, all write enables are forced to 0, illegal=0 and retired=0.
  - On the first edge with reset=0, state is FETCH.
  - Reset asserted mid-instruction aborts it with no writes; retired is not incremented.
- retired updates on the clock edge that leaves the retiring state. Its output is visible the following cycle.

## Structure
- Shared package `cpu_pkg`: the opcode constants, ALUOp constants, state encodings and alu_src_b/pc_source encodings. The ALU and datapath use these same constants.
- Optional sub-module `alu_op_decode`: a combinational mapping from opcode to ALUOp for the R-type group. Everything else stays in a single FSM module.

## Test plan
- ADD (opcode 0), mem_ready held 1: states 0→1→2→7→0. ALUOp=000 in EXEC_R, reg_write=1 and reg_dst=1 in WB_ALU, retired 0→1.
- LW with mem_ready low for 2 cycles in MEM_RD: MEM_RD lasts 3 cycles with mem_read stable, then WB_MEM with mem_to_reg=1. Total 7 cycles.
- BEQ with alu_zero=1, then BEQ with alu_zero=0: ALUOp=010 and pc_write_cond=1 in BRANCH both times. Each takes 3 cycles; retired +2.
- XOR/OR/AND/SUB back-to-back: EXEC_R shows ALUOp 101/110/100/010 respectively.
- Opcode 12: after DECODE, state=11 and illegal=1 held for 10 cycles with no enables. reset=1 returns to FETCH and illegal=0.
- Reset asserted during MEM_WR with mem_ready=0: next state FETCH, mem_write never pulses, retired unchanged. Separately, preload 65535 retirements: wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes, control FSM state
// encodings and datapath mux select encodings. The ALU, datapath and control
// unit all draw on these constants so the encodings stay in one place.
package cpu_pkg;

   // Instruction opcodes, bits [15:12] of the instruction register
   localparam logic [3:0] OpcAdd  = 4'd0;
   localparam logic [3:0] OpcSub  = 4'd1;
   localparam logic [3:0] OpcAnd  = 4'd2;
   localparam logic [3:0] OpcXor  = 4'd3;
   localparam logic [3:0] OpcOr   = 4'd4;
   localparam logic [3:0] OpcAddi = 4'd5;
   localparam logic [3:0] OpcLw   = 4'd6;
   localparam logic [3:0] OpcSw   = 4'd7;
   localparam logic [3:0] OpcBeq  = 4'd8;
   localparam logic [3:0] OpcJ    = 4'd9;

   // ALU operation select
   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b010;
   localparam logic [2:0] AluAnd = 3'b100;
   localparam logic [2:0] AluXor = 3'b101;
   localparam logic [2:0] AluOr  = 3'b110;

   // ALU A operand source
   localparam logic SrcAPc  = 1'b0;
   localparam logic SrcAReg = 1'b1;

   // ALU B operand source
   localparam logic [1:0] SrcBReg = 2'b00;
   localparam logic [1:0] SrcBOne = 2'b01;
   localparam logic [1:0] SrcBImm = 2'b10;

   // PC next-value source
   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   // Control FSM states; the numeric values are visible on the debug port
   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExecR  = 4'd2,
      StExecI  = 4'd3,
      StAddr   = 4'd4,
      StMemRd  = 4'd5,
      StMemWr  = 4'd6,
      StWbAlu  = 4'd7,
      StWbMem  = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10,
      StTrap   = 4'd11
   } state_t;

   // R-type group: register-register ALU instructions
   function automatic logic is_rtype(input logic [3:0] opc);
      return (opc <= OpcOr);
   endfunction

   // A state retires its instruction on the edge that leaves it; stores only
   // complete once memory accepts the write.
   function automatic logic state_retires(input state_t st, input logic mem_ready);
      logic r;
      r = 1'b0;
      case (st)
         StWbAlu, StWbMem, StBranch, StJump: r = 1'b1;
         StMemWr:                            r = mem_ready;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps an R-type opcode onto the ALU operation select. Opcodes outside the
// R-type group fall back to add, which is harmless since the FSM only uses
// this result in EXEC_R.
module alu_op_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] alu_op
);

   // Opcode to ALU function lookup
   always_comb begin
      alu_op = AluAdd;
      case (opcode)
         OpcAdd:  alu_op = AluAdd;
         OpcSub:  alu_op = AluSub;
         OpcAnd:  alu_op = AluAnd;
         OpcXor:  alu_op = AluXor;
         OpcOr:   alu_op = AluOr;
         default: alu_op = AluAdd;
      endcase
   end

endmodule

// File: rtl/alu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU. Steps each instruction through
// fetch, decode, execute, memory and writeback, driving the ALU select and
// every datapath enable/select as a Moore decode of the registered state.
// Stalls on memory, traps (stickily) on illegal opcodes and counts retired
// instructions.
module alu_control_fsm
   import cpu_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic [2:0]  ALUOp,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_source,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [15:0] retired
);

   state_t      state_q;
   logic [15:0] retired_q;
   logic [2:0]  rtype_op;
   logic        retire;

   alu_op_decode u_alu_op_decode (
      .opcode (opcode),
      .alu_op (rtype_op)
   );

   // alu_zero is consumed by the datapath through pc_write_cond; the control
   // sequence itself never branches on it.
   logic unused_alu_zero;
   assign unused_alu_zero = alu_zero;

   // Retire strobe; reset aborts the in-flight instruction without counting it
   assign retire = ~reset & state_retires(state_q, mem_ready);

   // State register, next-state sequencing and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= state_t'(RESET_STATE);
         retired_q <= 16'd0;
      end else begin
         if (retire) begin
            retired_q <= retired_q + 16'd1;
         end
         case (state_q)
            StFetch: begin
               if (mem_ready) begin
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               case (opcode)
                  OpcAdd, OpcSub, OpcAnd, OpcXor, OpcOr: state_q <= StExecR;
                  OpcAddi:                               state_q <= StExecI;
                  OpcLw, OpcSw:                          state_q <= StAddr;
                  OpcBeq:                                state_q <= StBranch;
                  OpcJ:                                  state_q <= StJump;
                  default:                               state_q <= StTrap;
               endcase
            end
            StExecR:  state_q <= StWbAlu;
            StExecI:  state_q <= StWbAlu;
            StAddr:   state_q <= (opcode == OpcLw) ? StMemRd : StMemWr;
            StMemRd: begin
               if (mem_ready) begin
                  state_q <= StWbMem;
               end
            end
            StMemWr: begin
               if (mem_ready) begin
                  state_q <= StFetch;
               end
            end
            StWbAlu:  state_q <= StFetch;
            StWbMem:  state_q <= StFetch;
            StBranch: state_q <= StFetch;
            StJump:   state_q <= StFetch;
            StTrap:   state_q <= StTrap;
            default:  state_q <= StFetch;
         endcase
      end
   end

   // Moore output decode; only the FETCH IR/PC writes look at mem_ready, and
   // reset masks every write enable so an aborted instruction leaves no trace.
   always_comb begin
      ALUOp         = AluAdd;
      alu_src_a     = SrcAPc;
      alu_src_b     = SrcBReg;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PcSrcAlu;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = SrcBOne;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            pc_source = PcSrcAlu;
         end
         StDecode: begin
            // Precompute the branch target into ALUOut
            alu_src_b = SrcBImm;
         end
         StExecR: begin
            alu_src_a = SrcAReg;
            alu_src_b = SrcBReg;
            ALUOp     = rtype_op;
         end
         StExecI, StAddr: begin
            alu_src_a = SrcAReg;
            alu_src_b = SrcBImm;
         end
         StMemRd: begin
            mem_read = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
         end
         StWbAlu: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype(opcode);
         end
         StWbMem: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StBranch: begin
            alu_src_a     = SrcAReg;
            alu_src_b     = SrcBReg;
            ALUOp         = AluSub;
            pc_write_cond = 1'b1;
            pc_source     = PcSrcAluOut;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = PcSrcJump;
         end
         StTrap: begin
            illegal = 1'b1;
         end
         default: begin
         end
      endcase
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         illegal       = 1'b0;
      end
   end

   assign state   = state_q;
   assign retired = reset ? 16'd0 : retired_q;

endmodule
